// File: rtl/can_stuff.sv
// CAN transmit bit stuffer.
// Takes unstuffed frame bits over a valid/ready handshake and serialises each
// one for CLKS_PER_BIT clocks. After five equal bits in the stuffed region it
// inserts one complementary stuff bit. The idle bus level is recessive (1).
// Optional readback monitor: define CAN_STUFF_BIT_MONITOR_EN to compare
// i_Rx_Serial against the driven bit at SAMPLE_POINT and pulse o_Bit_Error.
module can_stuff #(
  parameter int CLKS_PER_BIT = 50,
  parameter int SAMPLE_POINT = 35
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Tx_Bit,
  input  logic i_Tx_Stuff_En,
  input  logic i_Tx_Valid,
  output logic o_Tx_Ready,
  output logic o_Tx_Serial,
  output logic o_Stuff_Bit,
  output logic o_Busy,
  input  logic i_Rx_Serial,
  output logic o_Bit_Error
);

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TIMER_LAST   = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TIMER_SAMPLE = TW'(SAMPLE_POINT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    STUFF = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [2:0]      run_reg, run_next;
  logic            last_reg, last_next;
  logic            tx_reg, tx_next;

  logic            period_end;
  logic            stuff_due;
  logic            xfer;
  logic [2:0]      load_run;
  logic            load_last;

  assign period_end = (timer_reg == TIMER_LAST);
  // Five equal stuffed-region bits have gone out: a stuff bit must follow.
  assign stuff_due  = (run_reg == 3'd5);
  assign xfer       = i_Tx_Valid && o_Tx_Ready;

  // Ready: always in IDLE, at the end of a data bit unless a stuff bit is
  // pending, and at the end of a stuff bit when upstream already has data.
  always_comb begin
    o_Tx_Ready = 1'b0;
    if (!i_Reset) begin
      case (state_reg)
        IDLE:    o_Tx_Ready = 1'b1;
        DATA:    o_Tx_Ready = period_end && !stuff_due;
        STUFF:   o_Tx_Ready = period_end && i_Tx_Valid;
        default: o_Tx_Ready = 1'b0;
      endcase
    end
  end

  // Run tracking applied when a data bit is accepted.
  always_comb begin
    load_run  = 3'd0;
    load_last = last_reg;
    if (i_Tx_Stuff_En) begin
      if ((i_Tx_Bit == last_reg) && (run_reg != 3'd0)) begin
        load_run = (run_reg == 3'd5) ? 3'd5 : (run_reg + 3'd1);
      end else begin
        load_run  = 3'd1;
        load_last = i_Tx_Bit;
      end
    end
  end

  // Next-state logic: bit timer, stuff insertion and data loading.
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    run_next   = run_reg;
    last_next  = last_reg;
    tx_next    = tx_reg;
    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (xfer) begin
          state_next = DATA;
          timer_next = '0;
          tx_next    = i_Tx_Bit;
          run_next   = load_run;
          last_next  = load_last;
        end
      end
      DATA: begin
        if (!period_end) begin
          timer_next = timer_reg + TW'(1);
        end else if (stuff_due) begin
          // The stuff bit itself begins a new run of length one.
          state_next = STUFF;
          timer_next = '0;
          tx_next    = ~last_reg;
          run_next   = 3'd1;
          last_next  = ~last_reg;
        end else if (xfer) begin
          timer_next = '0;
          tx_next    = i_Tx_Bit;
          run_next   = load_run;
          last_next  = load_last;
        end else begin
          state_next = IDLE;
          timer_next = '0;
          tx_next    = 1'b1;
          run_next   = 3'd0;
        end
      end
      STUFF: begin
        if (!period_end) begin
          timer_next = timer_reg + TW'(1);
        end else if (xfer) begin
          state_next = DATA;
          timer_next = '0;
          tx_next    = i_Tx_Bit;
          run_next   = load_run;
          last_next  = load_last;
        end else begin
          state_next = IDLE;
          timer_next = '0;
          tx_next    = 1'b1;
          run_next   = 3'd0;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
        tx_next    = 1'b1;
        run_next   = 3'd0;
      end
    endcase
  end

  // State register; reset drops the bus back to recessive immediately.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      run_reg   <= 3'd0;
      last_reg  <= 1'b1;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      run_reg   <= run_next;
      last_reg  <= last_next;
      tx_reg    <= tx_next;
    end
  end

  assign o_Tx_Serial = tx_reg;
  assign o_Busy      = (state_reg != IDLE);
  assign o_Stuff_Bit = (state_reg == STUFF);

`ifdef CAN_STUFF_BIT_MONITOR_EN
  // Readback compare at the sample point of every transmitted bit.
  assign o_Bit_Error = (state_reg != IDLE) && (timer_reg == TIMER_SAMPLE) &&
                       (i_Rx_Serial != tx_reg);
`else
  logic monitor_unused;
  assign monitor_unused = i_Rx_Serial ^ (timer_reg == TIMER_SAMPLE);
  assign o_Bit_Error    = 1'b0;
`endif

endmodule

// File: tb/tb_can_stuff.sv
// Testbench for can_stuff: a driver pushes the model's expected stuffed bit
// stream into a queue, and a monitor reassembles bit periods from the serial
// output and compares them against the queue.
module tb_can_stuff;

  localparam int CPB = 4;
  localparam int SP  = 2;

  logic i_Clock = 1'b0;
  logic i_Reset = 1'b1;
  logic i_Tx_Bit = 1'b1;
  logic i_Tx_Stuff_En = 1'b0;
  logic i_Tx_Valid = 1'b0;
  logic i_Rx_Serial;
  logic o_Tx_Ready, o_Tx_Serial, o_Stuff_Bit, o_Busy, o_Bit_Error;
  logic rx_force = 1'b0;

  assign i_Rx_Serial = rx_force ? 1'b0 : o_Tx_Serial;

  can_stuff #(.CLKS_PER_BIT(CPB), .SAMPLE_POINT(SP)) dut (
    .i_Clock(i_Clock),
    .i_Reset(i_Reset),
    .i_Tx_Bit(i_Tx_Bit),
    .i_Tx_Stuff_En(i_Tx_Stuff_En),
    .i_Tx_Valid(i_Tx_Valid),
    .o_Tx_Ready(o_Tx_Ready),
    .o_Tx_Serial(o_Tx_Serial),
    .o_Stuff_Bit(o_Stuff_Bit),
    .o_Busy(o_Busy),
    .i_Rx_Serial(i_Rx_Serial),
    .o_Bit_Error(o_Bit_Error)
  );

  always #5 i_Clock = ~i_Clock;

  typedef struct packed {
    logic v;
    logic s;
  } exp_t;

  exp_t exp_q[$];
  bit   f_bit[$];
  bit   f_en[$];

  int errors = 0;
  int checks = 0;
  int err_pulses = 0;
  int bits_seen = 0;

  int   cyc = 0;
  logic per_val, per_stf;
  bit   per_ok;

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic add(input bit b, input bit e);
    f_bit.push_back(b);
    f_en.push_back(e);
  endtask

  // Reference: walk the frame as a list; every fifth equal bit inside the
  // stuffed region is followed by its complement, which starts a new run.
  task automatic model_frame();
    bit   last = 1'b1;
    int   run = 0;
    exp_t e;
    for (int i = 0; i < f_bit.size(); i++) begin
      e.v = f_bit[i];
      e.s = 1'b0;
      exp_q.push_back(e);
      if (f_en[i]) begin
        if (run > 0 && f_bit[i] == last) run++;
        else begin
          run  = 1;
          last = f_bit[i];
        end
        if (run == 5) begin
          e.v = ~last;
          e.s = 1'b1;
          exp_q.push_back(e);
          last = ~last;
          run  = 1;
        end
      end else begin
        run = 0;
      end
    end
  endtask

  // Drive one frame back-to-back, then wait for the block to return to idle.
  task automatic send_frame(input string name);
    int w;
    model_frame();
    for (int i = 0; i < f_bit.size(); i++) begin
      @(negedge i_Clock);
      i_Tx_Bit      = f_bit[i];
      i_Tx_Stuff_En = f_en[i];
      i_Tx_Valid    = 1'b1;
      w = 0;
      while (!o_Tx_Ready && w < 8 * CPB) begin
        @(negedge i_Clock);
        w++;
      end
      if (!o_Tx_Ready) begin
        errors++;
        checks++;
        $display("FAIL %s ready_timeout at bit %0d: ready=0 required 1", name, i);
        i_Tx_Valid = 1'b0;
        f_bit.delete();
        f_en.delete();
        return;
      end
      @(posedge i_Clock);
    end
    @(negedge i_Clock);
    i_Tx_Valid = 1'b0;
    w = 0;
    while (o_Busy && w < 8 * CPB) begin
      @(negedge i_Clock);
      w++;
    end
    chk({name, " idle_busy"}, o_Busy, 1'b0);
    chk({name, " idle_serial"}, o_Tx_Serial, 1'b1);
    chk({name, " idle_ready"}, o_Tx_Ready, 1'b1);
    chk_int({name, " queue_drained"}, exp_q.size(), 0);
    exp_q.delete();
    f_bit.delete();
    f_en.delete();
  endtask

  // Monitor: rebuild each bit period from the serial line and score it.
  always @(negedge i_Clock) begin
    if (i_Reset) begin
      cyc = 0;
    end else if (o_Busy) begin
      if (cyc == 0) begin
        per_val = o_Tx_Serial;
        per_stf = o_Stuff_Bit;
        per_ok  = 1'b1;
      end else if (o_Tx_Serial !== per_val || o_Stuff_Bit !== per_stf) begin
        per_ok = 1'b0;
      end
      if (o_Stuff_Bit && cyc < CPB - 1) begin
        checks++;
        if (o_Tx_Ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_in_stuff: got %b required 0", o_Tx_Ready);
        end
      end
      cyc++;
      if (cyc == CPB) begin
        cyc = 0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_bit: serial=%b stuff=%b with nothing expected",
                   per_val, per_stf);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("bit %0d: serial=%b stuff=%b held=%0d model=%b/%b",
                   bits_seen, per_val, per_stf, per_ok, e.v, e.s);
          if (!per_ok || per_val !== e.v || per_stf !== e.s) begin
            errors++;
            $display("FAIL bit_%0d: serial/stuff=%b/%b held=%0d required %b/%b held=1",
                     bits_seen, per_val, per_stf, per_ok, e.v, e.s);
          end
        end
        bits_seen++;
      end
    end else begin
      if (cyc != 0) begin
        checks++;
        errors++;
        $display("FAIL period_length: busy ended after %0d clocks required %0d", cyc, CPB);
      end
      cyc = 0;
    end
    if (!i_Reset && o_Bit_Error) err_pulses++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_err;
    int len, k;
    bit b;

    repeat (2) @(negedge i_Clock);
    chk("reset_serial", o_Tx_Serial, 1'b1);
    chk("reset_busy", o_Busy, 1'b0);
    chk("reset_stuff", o_Stuff_Bit, 1'b0);
    chk("reset_ready", o_Tx_Ready, 1'b0);
    chk("reset_bit_error", o_Bit_Error, 1'b0);
    i_Reset = 1'b0;
    #1 chk("post_reset_ready", o_Tx_Ready, 1'b1);

    // Five dominant bits then a recessive one: one recessive stuff bit.
    for (int i = 0; i < 5; i++) add(1'b0, 1'b1);
    add(1'b1, 1'b1);
    send_frame("five_zeros");

    // Eleven recessive bits: two dominant stuff bits.
    for (int i = 0; i < 11; i++) add(1'b1, 1'b1);
    send_frame("eleven_ones");

    // Stuffed prefix without a five-run, then an unstuffed tail of ones.
    for (int i = 0; i < 4; i++) add(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) add(1'b0, 1'b1);
    add(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) add(1'b1, 1'b0);
    send_frame("unstuffed_tail");

    // Underrun after three bits; the next burst must start a fresh run.
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1);
    send_frame("underrun_a");
    for (int i = 0; i < 4; i++) add(1'b0, 1'b1);
    send_frame("underrun_b");

    // Reset during a dominant bit must release the bus without a clock edge.
    @(negedge i_Clock);
    i_Tx_Bit = 1'b0;
    i_Tx_Stuff_En = 1'b1;
    i_Tx_Valid = 1'b1;
    @(posedge i_Clock);
    @(negedge i_Clock);
    i_Tx_Valid = 1'b0;
    @(posedge i_Clock);
    @(posedge i_Clock);
    #1 chk("pre_reset_dominant", o_Tx_Serial, 1'b0);
    i_Reset = 1'b1;
    #1;
    chk("async_reset_serial", o_Tx_Serial, 1'b1);
    chk("async_reset_busy", o_Busy, 1'b0);
    chk("async_reset_ready", o_Tx_Ready, 1'b0);
    @(negedge i_Clock);
    @(negedge i_Clock);
    i_Reset = 1'b0;
    #1;
    chk("release_ready", o_Tx_Ready, 1'b1);
    chk("release_serial", o_Tx_Serial, 1'b1);
    for (int i = 0; i < 6; i++) add(1'b0, 1'b1);
    send_frame("after_reset");

    // Readback forced dominant while a recessive bit is sent.
`ifdef CAN_STUFF_BIT_MONITOR_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    rx_force = 1'b1;
    add(1'b1, 1'b1);
    send_frame("readback");
    rx_force = 1'b0;

    // Random frames biased toward long runs.
    for (int f = 0; f < 12; f++) begin
      len = $urandom_range(3, 30);
      k   = $urandom_range(1, len);
      b   = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) b = ~b;
        add(b, (i < k) ? 1'b1 : 1'b0);
      end
      send_frame($sformatf("random_%0d", f));
      repeat ($urandom_range(0, 3)) @(negedge i_Clock);
    end

    chk_int("bit_error_pulses", err_pulses, exp_err);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
